// File: rtl/if_prefetch_unit_if.sv
// Memory fetch bus and decode-side instruction handshake
// for the decoupled instruction prefetcher.
interface if_prefetch_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_o;
    logic [ADDR_W-1:0] req_addr_o;
    logic              gnt_i;
    logic              rvalid_i;
    logic [DATA_W-1:0] rdata_i;
    logic              ins_valid_o;
    logic              ins_ready_i;
    logic [DATA_W-1:0] ins_o;
    logic [ADDR_W-1:0] ins_addr_o;

    modport master (
        output req_o,
        output req_addr_o,
        input  gnt_i,
        input  rvalid_i,
        input  rdata_i,
        output ins_valid_o,
        input  ins_ready_i,
        output ins_o,
        output ins_addr_o
    );

    modport slave (
        input  req_o,
        input  req_addr_o,
        output gnt_i,
        output rvalid_i,
        output rdata_i,
        input  ins_valid_o,
        output ins_ready_i,
        input  ins_o,
        input  ins_addr_o
    );
endinterface

// File: rtl/if_prefetch_unit.sv
// Decoupled instruction prefetcher: credit-limited sequential fetch,
// in-order response buffering and jump flush with stale-response discard.
module if_prefetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       INT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         hold_flag_i,
    input  logic               jump_flag_i,
    input  logic [ADDR_W-1:0]  jump_addr_i,
    input  logic [INT_W-1:0]   int_flag_i,
    output logic [INT_W-1:0]   int_flag_o,
    if_prefetch_unit_if.master bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    localparam logic [ADDR_W-1:0] ALIGN    = ~ADDR_W'(3);
    localparam logic [DATA_W-1:0] NOP      = DATA_W'(32'h0000_0013);
    localparam logic [CW:0]       CRED_MAX = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     discard;
    logic [CW-1:0]     fcnt;
    logic [CW:0]       credit;

    logic [PW-1:0]     aq_wp;
    logic [PW-1:0]     aq_rp;
    logic [PW-1:0]     f_wp;
    logic [PW-1:0]     f_rp;

    logic [ADDR_W-1:0] aq_mem [DEPTH];
    logic [ADDR_W-1:0] fa_mem [DEPTH];
    logic [DATA_W-1:0] fd_mem [DEPTH];

    logic can_req;
    logic issue;
    logic resp;
    logic drop;
    logic push;
    logic pop;
    logic head_vld;

    // Credit covers both buffered entries and requests still in flight,
    // so every granted request is guaranteed a FIFO slot on return.
    always_comb begin
        credit  = {1'b0, fcnt} + {1'b0, outstanding};
        can_req = !rst
                  && !jump_flag_i
                  && (hold_flag_i == 3'd0)
                  && (credit < CRED_MAX);
    end

    always_comb begin
        head_vld = (fcnt != '0);
        issue    = can_req && bus.gnt_i;
        resp     = bus.rvalid_i;
        drop     = resp && (jump_flag_i || (discard != '0));
        push     = resp && !drop;
        pop      = head_vld && bus.ins_ready_i && !jump_flag_i;
    end

    assign bus.req_o       = can_req;
    assign bus.req_addr_o  = fetch_pc;
    assign bus.ins_valid_o = head_vld;
    assign bus.ins_o       = head_vld ? fd_mem[f_rp] : NOP;
    assign bus.ins_addr_o  = head_vld ? fa_mem[f_rp] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC & ALIGN;
        end else if (jump_flag_i) begin
            fetch_pc <= jump_addr_i & ALIGN;
        end else if (issue) begin
            fetch_pc <= fetch_pc + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(resp);
        end
    end

    // Everything still in flight at a jump belongs to the old path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            discard <= '0;
        end else if (jump_flag_i) begin
            discard <= outstanding - CW'(resp);
        end else if (resp && (discard != '0)) begin
            discard <= discard - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aq_wp <= '0;
            aq_rp <= '0;
        end else if (jump_flag_i) begin
            aq_wp <= '0;
            aq_rp <= '0;
        end else begin
            if (issue) begin
                aq_wp <= aq_wp + PW'(1);
            end
            if (push) begin
                aq_rp <= aq_rp + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            aq_mem[aq_wp] <= fetch_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_wp <= '0;
            f_rp <= '0;
            fcnt <= '0;
        end else if (jump_flag_i) begin
            f_wp <= '0;
            f_rp <= '0;
            fcnt <= '0;
        end else begin
            if (push) begin
                f_wp <= f_wp + PW'(1);
            end
            if (pop) begin
                f_rp <= f_rp + PW'(1);
            end
            fcnt <= fcnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fa_mem[f_wp] <= aq_mem[aq_rp];
            fd_mem[f_wp] <= bus.rdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_flag_o <= '0;
        end else if (jump_flag_i) begin
            int_flag_o <= '0;
        end else begin
            int_flag_o <= int_flag_i;
        end
    end
endmodule
